wb_data_bridge: RTL

Registered bridge between the core's req/ack data port and the Wishbone-style data memory bus (`data_mem_*`) served by the Controller. It latches one core request, runs a single bus cycle, registers the returned data and acknowledge, and presents a one-cycle `core_ack` back to the core. It sits directly downstream of the core's data interface and upstream of the Controller's second memory port. It replaces the ad-hoc ack flop in the top level with a defined handshake and an optional bus watchdog.

---
 rtl/wb_data_bridge.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/wb_data_bridge.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : wb_data_bridge                                               |
// | Description : Registered bridge from the core req/ack data port to the     |
// |               Wishbone-style data memory bus. Latches one request, runs a  |
// |               single bus cycle, returns a one-cycle core_ack.              |
// |               Optional bus watchdog enabled by defining BRIDGE_TIMEOUT_EN. |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module wb_data_bridge #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                  sys_clk,
    input  logic                  rst_n,
    input  logic                  core_req,
    input  logic [ADDR_WIDTH-1:0] core_addr,
    input  logic                  core_wr_en,
    input  logic [DATA_WIDTH-1:0] core_wr_data,
    input  logic [3:0]            core_mask,
    output logic [DATA_WIDTH-1:0] core_rd_data,
    output logic                  core_ack,
    output logic                  data_mem_cyc,
    output logic                  data_mem_stb,
    output logic                  data_mem_we,
    output logic [3:0]            data_mem_wstrb,
    output logic [ADDR_WIDTH-1:0] data_mem_addr,
    output logic [DATA_WIDTH-1:0] data_mem_data_out,
    input  logic [DATA_WIDTH-1:0] data_mem_data_in,
    input  logic                  data_mem_ack,
    output logic                  bus_error
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUS  = 2'd1,
        S_RESP = 2'd2
    } state_t;

    // Only a 32-bit data path with 4 byte strobes and a 16-bit watchdog count
    // are supported; an illegal configuration elaborates this marker block.
    if (DATA_WIDTH != 32 || TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_config
        logic unsupported_configuration;
    end

    state_t                r_state;
    logic [ADDR_WIDTH-1:0] r_req_addr;
    logic                  r_req_we;
    logic [DATA_WIDTH-1:0] r_req_wdata;
    logic [3:0]            r_req_mask;
    logic [DATA_WIDTH-1:0] r_rd_data;
    logic                  r_ack;
    logic                  w_in_bus;

`ifdef BRIDGE_TIMEOUT_EN
    localparam logic [DATA_WIDTH-1:0] c_abort_data   = DATA_WIDTH'(32'hDEADBEEF);
    localparam logic [15:0]           c_timeout_last = 16'(TIMEOUT_CYCLES - 1);

    logic [15:0] r_count;
    logic        r_bus_error;

    // Request FSM with watchdog: an unanswered bus cycle is aborted after
    // TIMEOUT_CYCLES cycles of strobe; a same-cycle ack still wins.
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_req_addr  <= '0;
            r_req_we    <= 1'b0;
            r_req_wdata <= '0;
            r_req_mask  <= 4'h0;
            r_rd_data   <= '0;
            r_ack       <= 1'b0;
            r_bus_error <= 1'b0;
            r_count     <= 16'h0;
        end else begin
            r_ack       <= 1'b0;
            r_bus_error <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (core_req) begin
                        r_req_addr  <= core_addr;
                        r_req_we    <= core_wr_en;
                        r_req_wdata <= core_wr_data;
                        r_req_mask  <= core_mask;
                        r_count     <= 16'h0;
                        r_state     <= S_BUS;
                    end
                end
                S_BUS: begin
                    if (data_mem_ack) begin
                        if (!r_req_we) begin
                            r_rd_data <= data_mem_data_in;
                        end
                        r_ack   <= 1'b1;
                        r_state <= S_RESP;
                    end else if (r_count == c_timeout_last) begin
                        if (!r_req_we) begin
                            r_rd_data <= c_abort_data;
                        end
                        r_ack       <= 1'b1;
                        r_bus_error <= 1'b1;
                        r_state     <= S_RESP;
                    end else begin
                        r_count <= r_count + 16'h1;
                    end
                end
                S_RESP:  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus_error = r_bus_error;
`else
    // Request FSM: BUS waits as long as it takes for the bus acknowledge.
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_req_addr  <= '0;
            r_req_we    <= 1'b0;
            r_req_wdata <= '0;
            r_req_mask  <= 4'h0;
            r_rd_data   <= '0;
            r_ack       <= 1'b0;
        end else begin
            r_ack <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (core_req) begin
                        r_req_addr  <= core_addr;
                        r_req_we    <= core_wr_en;
                        r_req_wdata <= core_wr_data;
                        r_req_mask  <= core_mask;
                        r_state     <= S_BUS;
                    end
                end
                S_BUS: begin
                    if (data_mem_ack) begin
                        if (!r_req_we) begin
                            r_rd_data <= data_mem_data_in;
                        end
                        r_ack   <= 1'b1;
                        r_state <= S_RESP;
                    end
                end
                S_RESP:  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus_error = 1'b0;
`endif

    // Bus signals are decoded from state and the request registers only, so
    // they fall to zero the moment reset clears the state register.
    assign w_in_bus          = (r_state == S_BUS);
    assign data_mem_cyc      = w_in_bus;
    assign data_mem_stb      = w_in_bus;
    assign data_mem_we       = w_in_bus & r_req_we;
    assign data_mem_wstrb    = (w_in_bus && r_req_we) ? r_req_mask : 4'h0;
    assign data_mem_addr     = w_in_bus ? r_req_addr : '0;
    assign data_mem_data_out = w_in_bus ? r_req_wdata : '0;
    assign core_rd_data      = r_rd_data;
    assign core_ack          = r_ack;

endmodule
`default_nettype wire
